fod_half_div_ctrl: RTL and testbench
====================================

// Module: fod_half_div_ctrl
// PURPOSE
// - Fractional-output-divider control stage; feeds the pos/neg retimer directly downstream.
// - Divides CK by a programmable ratio in half-CK units with a first-order fractional accumulator.
// - Emits the coarse divided pulse DIV_OUT and the POLARITY select.
//   - POLARITY=1: the retimer uses its posedge path and adds a half cycle.
//   - POLARITY=0: the retimer uses its negedge path.
// - Together they place every output edge on a half-CK grid.
// PARAMETERS
// - DIV_W   8   width of DIV_HC (integer period, in half-CK cycles)
// - FRAC_W  16  width of DIV_FRAC and of the fractional accumulator
// PORTS
// - CK        in   1       clock; one clock domain only
// - NRST      in   1       reset, asynchronous, active-low
// - EN        in   1       run request
// - LOAD      in   1       1-cycle strobe: capture DIV_HC/DIV_FRAC into the pending register
// - DIV_HC    in   DIV_W   integer period in half-CK cycles; values <4 are clamped to 4
// - DIV_FRAC  in   FRAC_W  fractional half-cycle, unsigned, /2^FRAC_W
// - LOAD_ACK  out  1       1-cycle pulse when the pending config becomes active
// - DIV_OUT   out  1       divided clock, to the retimer D input
// - POLARITY  out  1       half-cycle offset of the next DIV_OUT edge, to the retimer POLARITY input
// BEHAVIOUR
// - Reset (async, NRST=0): all outputs 0.
//   - State IDLE; counter, phase bit h, accumulator and active/pending config all 0.
//   - Reset mid-period aborts immediately with no partial pulse.
// - States
//   - IDLE: on EN=1, go to RUN next cycle with h=0, acc=0; the first period starts there.
//   - RUN: see period computation below.
//   - DRAIN: on EN=0 in RUN, finish the current period, then go to IDLE with DIV_OUT=0 and POLARITY held.
//   - EN returning to 1 in DRAIN is ignored until IDLE is reached.
// - Period computation, at each period start (cycle DIV_OUT rises):
//   - {c, acc} = acc + DIV_FRAC_act  (carry c, FRAC_W-bit wrap)
//   - L = max(DIV_HC_act, 4) + c  (DIV_W+1 bits, no overflow)
//   - T = h + L;  Ncyc = T>>1;  h_next = T[0]
//   - Counter runs 0..Ncyc-1; the next period starts when it reaches Ncyc-1.
// - DIV_OUT: 1 for counter < Ncyc>>1, else 0; always ≥1 cycle high and ≥1 cycle low, since Ncyc≥2.
// - POLARITY
//   - Registered at period start to h of the following edge (h_next).
//   - Therefore stable from the rise of DIV_OUT through its fall, where the retimer samples it.
//   - It also retimes the following falling edge, so the duty cycle may shift by a half cycle.
// - LOAD
//   - Pending register written on LOAD=1 in any state; a later LOAD before activation overwrites it.
//   - Pending copied to active at the next period start, or on the IDLE->RUN transition.
//   - LOAD_ACK pulses in that cycle.
//   - LOAD in the same cycle as a period start: the old pending value is applied and the new one waits.
//   - acc is not cleared on a config change.
// - DIV_FRAC=0: exactly periodic at L half-cycles.
// - Mean period = DIV_HC + DIV_FRAC/2^FRAC_W half-cycles.
// STRUCTURE
// - Shared package fod_pkg:
//   - state enum fod_div_st_e {IDLE, RUN, DRAIN}
//   - localparam MIN_DIV_HC=4
//   - typedef fod_cfg_t {hc, frac}
// - Sub-module fod_frac_acc: FRAC_W accumulator.
//   - Ports: CK, NRST, STEP, FRAC -> CARRY.
//   - Advances only on STEP (period start).
// - Top: FSM, cycle counter, h register, config shadowing, output registers; all outputs registered.
// TESTING
// - NRST low mid-RUN (DIV_HC=6) -> DIV_OUT, POLARITY and LOAD_ACK all 0 asynchronously; after release the block stays IDLE until EN.
// - DIV_HC=5, FRAC=0, EN=1 -> Ncyc sequence 2,3,2,3; POLARITY sequence 1,0,1,0; mean period 2.5 CK.
// - DIV_HC=8, FRAC=0x8000 -> L alternates 8,9; h pattern gives edge spacing 4.0/4.5 CK; mean 8.5 half-cycles over 64 periods.
// - DIV_HC=2 -> clamped to 4: Ncyc=2, DIV_OUT 1 cycle high and 1 low, POLARITY constant 0.
// - LOAD DIV_HC 6->9 mid-period -> LOAD_ACK exactly at the next DIV_OUT rise; new Ncyc applied from that period.
// - EN dropped 1 cycle after a period start (DIV_HC=10) -> the period completes (5 CK), then IDLE with DIV_OUT=0 and no further pulse.

Source files
------------

// File: rtl/fod_pkg.sv
// Shared types and constants for the fractional-output-divider control stage.
package fod_pkg;

    localparam int CFG_DIV_W  = 8;
    localparam int CFG_FRAC_W = 16;
    localparam int MIN_DIV_HC = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fod_div_st_e;

    typedef struct packed {
        logic [CFG_DIV_W-1:0]  hc;
        logic [CFG_FRAC_W-1:0] frac;
    } fod_cfg_t;

endpackage

// File: rtl/fod_frac_acc.sv
// First-order fractional accumulator; the carry lengthens the current period by one half-cycle.
module fod_frac_acc #(
    parameter int FRAC_W = 16
) (
    input  logic              CK,
    input  logic              NRST,
    input  logic              STEP,
    input  logic              CLR,
    input  logic [FRAC_W-1:0] FRAC,
    output logic              CARRY
);

    logic [FRAC_W-1:0] acc;
    logic [FRAC_W-1:0] base;
    logic [FRAC_W:0]   sum;

    // CLR makes the accumulator read as zero so a fresh run starts from a known phase.
    assign base  = CLR ? '0 : acc;
    assign sum   = {1'b0, base} + {1'b0, FRAC};
    assign CARRY = sum[FRAC_W];

    always_ff @(posedge CK or negedge NRST) begin
        if (!NRST) begin
            acc <= '0;
        end else if (STEP) begin
            acc <= sum[FRAC_W-1:0];
        end else if (CLR) begin
            acc <= '0;
        end
    end

endmodule

// File: rtl/fod_half_div_ctrl.sv
// Divider control: computes each period in half-CK units and emits DIV_OUT plus the
// POLARITY select that tells the downstream retimer whether to add a half cycle.
module fod_half_div_ctrl
    import fod_pkg::*;
#(
    parameter int DIV_W  = CFG_DIV_W,
    parameter int FRAC_W = CFG_FRAC_W
) (
    input  logic              CK,
    input  logic              NRST,
    input  logic              EN,
    input  logic              LOAD,
    input  logic [DIV_W-1:0]  DIV_HC,
    input  logic [FRAC_W-1:0] DIV_FRAC,
    output logic              LOAD_ACK,
    output logic              DIV_OUT,
    output logic              POLARITY
);

    localparam int CW = DIV_W + 1;

    fod_div_st_e      state, state_nxt;
    fod_cfg_t         pend, act, cfg_eff;
    logic             pend_valid;
    logic             h, h_eff, h_new;
    logic             carry;
    logic             period_end, start, apply, div_nxt;
    logic [CW-1:0]    cnt, ncyc, cnt_nxt, ncyc_nxt, ncyc_new, ncyc_m1;
    logic [DIV_W-1:0] hc_cl;
    logic [DIV_W+1:0] t_sum;

    assign ncyc_m1    = ncyc - CW'(1);
    assign period_end = (state != IDLE) && (cnt == ncyc_m1);
    assign start      = (state == IDLE) ? EN : (period_end && (state == RUN) && EN);
    assign apply      = start && pend_valid;

    // A pending config takes effect for the very period it is applied in.
    assign cfg_eff = apply ? pend : act;
    assign h_eff   = (state == IDLE) ? 1'b0 : h;
    assign hc_cl   = (cfg_eff.hc < DIV_W'(MIN_DIV_HC)) ? DIV_W'(MIN_DIV_HC) : cfg_eff.hc;

    // T = h + L in half-cycles; the whole part is the CK count, the odd bit carries over.
    assign t_sum    = {2'b00, hc_cl} + {{(DIV_W+1){1'b0}}, carry} + {{(DIV_W+1){1'b0}}, h_eff};
    assign ncyc_new = t_sum[DIV_W+1:1];
    assign h_new    = t_sum[0];

    fod_frac_acc #(
        .FRAC_W(FRAC_W)
    ) u_acc (
        .CK    (CK),
        .NRST  (NRST),
        .STEP  (start),
        .CLR   (state == IDLE),
        .FRAC  (cfg_eff.frac),
        .CARRY (carry)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ncyc_nxt  = ncyc;
        if (start) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
            ncyc_nxt  = ncyc_new;
        end else if (state != IDLE) begin
            if (period_end) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + CW'(1);
                if ((state == RUN) && !EN) begin
                    state_nxt = DRAIN;
                end
            end
        end
    end

    assign div_nxt = (state_nxt != IDLE) && (cnt_nxt < (ncyc_nxt >> 1));

    always_ff @(posedge CK or negedge NRST) begin
        if (!NRST) begin
            state      <= IDLE;
            cnt        <= '0;
            ncyc       <= '0;
            h          <= 1'b0;
            pend       <= '0;
            pend_valid <= 1'b0;
            act        <= '0;
            LOAD_ACK   <= 1'b0;
            DIV_OUT    <= 1'b0;
            POLARITY   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ncyc     <= ncyc_nxt;
            LOAD_ACK <= apply;
            DIV_OUT  <= div_nxt;
            if (start) begin
                h        <= h_new;
                POLARITY <= h_new;
            end else if (state == IDLE) begin
                h <= 1'b0;
            end
            if (apply) begin
                act <= pend;
            end
            // A LOAD coinciding with an apply still wins, so the new value waits its turn.
            if (LOAD) begin
                pend       <= '{hc: DIV_HC, frac: DIV_FRAC};
                pend_valid <= 1'b1;
            end else if (apply) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fod_half_div_ctrl.sv
// Directed bench for fod_half_div_ctrl: a vector table of per-period CK counts and polarities
// plus hand-written sequences for reset, reconfiguration and drain.
module tb_fod_half_div_ctrl;

    logic        CK = 1'b0;
    logic        NRST = 1'b0;
    logic        EN = 1'b0;
    logic        LOAD = 1'b0;
    logic [7:0]  DIV_HC = '0;
    logic [15:0] DIV_FRAC = '0;
    logic        LOAD_ACK, DIV_OUT, POLARITY;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0]       hc;
        logic [15:0]      frac;
        logic [3:0][7:0]  n;
        logic [3:0]       pol;
    } vec_t;

    vec_t vecs [7];

    fod_half_div_ctrl dut (
        .CK       (CK),
        .NRST     (NRST),
        .EN       (EN),
        .LOAD     (LOAD),
        .DIV_HC   (DIV_HC),
        .DIV_FRAC (DIV_FRAC),
        .LOAD_ACK (LOAD_ACK),
        .DIV_OUT  (DIV_OUT),
        .POLARITY (POLARITY)
    );

    always #5 CK = ~CK;

    function automatic vec_t mk(input int hc, input int frac,
                                input int n0, input int n1, input int n2, input int n3,
                                input bit p0, input bit p1, input bit p2, input bit p3);
        vec_t v;
        v.hc   = 8'(hc);
        v.frac = 16'(frac);
        v.n[0] = 8'(n0);
        v.n[1] = 8'(n1);
        v.n[2] = 8'(n2);
        v.n[3] = 8'(n3);
        v.pol  = {p3, p2, p1, p0};
        return v;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic doReset();
        @(negedge CK);
        NRST = 1'b0;
        EN   = 1'b0;
        LOAD = 1'b0;
        @(negedge CK);
        NRST = 1'b1;
        @(negedge CK);
    endtask

    // Loads a config while idle, then raises EN; returns at the negedge after that.
    task automatic applyStimulus(input int hc, input int frac);
        LOAD     = 1'b1;
        DIV_HC   = 8'(hc);
        DIV_FRAC = 16'(frac);
        @(negedge CK);
        LOAD = 1'b0;
        EN   = 1'b1;
    endtask

    task automatic waitRise(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CK);
            if (DIV_OUT) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called at the negedge of a period's first cycle; returns at the next period's first cycle.
    task automatic measure(output int n, output int hi, output logic pol, output logic ack);
        logic last;
        pol  = POLARITY;
        ack  = LOAD_ACK;
        n    = 0;
        hi   = 0;
        last = 1'b1;
        while (n < 600) begin
            if (DIV_OUT) hi++;
            n++;
            last = DIV_OUT;
            @(negedge CK);
            LOAD = 1'b0;
            if (DIV_OUT && !last) break;
        end
    endtask

    initial begin
        int   n, hi, sum, pol_ones, highs, rises, first_rise;
        logic pol, ack, last;
        bit   ok;
        int   rst_hc [2];
        int   rst_n0 [2];

        vecs[0] = mk(5, 16'h0000, 2, 3, 2, 3, 1, 0, 1, 0);
        vecs[1] = mk(8, 16'h8000, 4, 4, 4, 5, 0, 1, 1, 0);
        vecs[2] = mk(2, 16'h0000, 2, 2, 2, 2, 0, 0, 0, 0);
        vecs[3] = mk(6, 16'h0000, 3, 3, 3, 3, 0, 0, 0, 0);
        vecs[4] = mk(7, 16'h0000, 3, 4, 3, 4, 1, 0, 1, 0);
        vecs[5] = mk(4, 16'h4000, 2, 2, 2, 2, 0, 0, 0, 1);
        vecs[6] = mk(3, 16'hC000, 2, 2, 3, 2, 0, 1, 0, 1);
        rst_hc = '{6, 5};
        rst_n0 = '{3, 2};

        #2;
        checkOutput("reset DIV_OUT", int'(DIV_OUT), 0);
        checkOutput("reset POLARITY", int'(POLARITY), 0);
        checkOutput("reset LOAD_ACK", int'(LOAD_ACK), 0);

        for (int v = 0; v < 7; v++) begin
            doReset();
            applyStimulus(int'(vecs[v].hc), int'(vecs[v].frac));
            waitRise(ok);
            checkOutput($sformatf("vec%0d first rise", v), int'(ok), 1);
            for (int p = 0; p < 4; p++) begin
                measure(n, hi, pol, ack);
                checkOutput($sformatf("vec%0d p%0d ncyc", v, p), n, int'(vecs[v].n[p]));
                checkOutput($sformatf("vec%0d p%0d high", v, p), hi, int'(vecs[v].n[p]) / 2);
                checkOutput($sformatf("vec%0d p%0d pol", v, p), int'(pol), int'(vecs[v].pol[p]));
                checkOutput($sformatf("vec%0d p%0d ack", v, p), int'(ack), (p == 0) ? 1 : 0);
            end
        end

        for (int r = 0; r < 2; r++) begin
            doReset();
            applyStimulus(rst_hc[r], 0);
            waitRise(ok);
            NRST = 1'b0;
            EN   = 1'b0;
            #1;
            checkOutput($sformatf("async rst hc%0d DIV_OUT", rst_hc[r]), int'(DIV_OUT), 0);
            checkOutput($sformatf("async rst hc%0d POLARITY", rst_hc[r]), int'(POLARITY), 0);
            checkOutput($sformatf("async rst hc%0d LOAD_ACK", rst_hc[r]), int'(LOAD_ACK), 0);
            @(negedge CK);
            NRST  = 1'b1;
            highs = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge CK);
                if (DIV_OUT) highs++;
            end
            checkOutput($sformatf("post rst hc%0d idle", rst_hc[r]), highs, 0);
            applyStimulus(rst_hc[r], 0);
            waitRise(ok);
            measure(n, hi, pol, ack);
            checkOutput($sformatf("post rst hc%0d ncyc", rst_hc[r]), n, rst_n0[r]);
        end

        doReset();
        applyStimulus(6, 0);
        waitRise(ok);
        measure(n, hi, pol, ack);
        checkOutput("reload p1 ncyc", n, 3);
        LOAD   = 1'b1;
        DIV_HC = 8'd9;
        measure(n, hi, pol, ack);
        checkOutput("reload p2 ncyc", n, 3);
        checkOutput("reload p2 ack", int'(ack), 0);
        measure(n, hi, pol, ack);
        checkOutput("reload p3 ncyc", n, 4);
        checkOutput("reload p3 ack", int'(ack), 1);
        checkOutput("reload p3 pol", int'(pol), 1);
        measure(n, hi, pol, ack);
        checkOutput("reload p4 ncyc", n, 5);
        checkOutput("reload p4 ack", int'(ack), 0);
        LOAD   = 1'b1;
        DIV_HC = 8'd6;
        @(negedge CK);
        LOAD = 1'b0;
        @(negedge CK);
        @(negedge CK);
        LOAD   = 1'b1;
        DIV_HC = 8'd4;
        checkOutput("reload p5 last low", int'(DIV_OUT), 0);
        @(negedge CK);
        LOAD = 1'b0;
        checkOutput("reload p5 next rise", int'(DIV_OUT), 1);
        measure(n, hi, pol, ack);
        checkOutput("edge load p6 ncyc", n, 3);
        checkOutput("edge load p6 ack", int'(ack), 1);
        checkOutput("edge load p6 pol", int'(pol), 1);
        measure(n, hi, pol, ack);
        checkOutput("edge load p7 ncyc", n, 2);
        checkOutput("edge load p7 ack", int'(ack), 1);
        measure(n, hi, pol, ack);
        checkOutput("edge load p8 ack", int'(ack), 0);
        checkOutput("edge load p8 pol", int'(pol), 1);

        doReset();
        applyStimulus(8, 16'h8000);
        waitRise(ok);
        sum      = 0;
        pol_ones = 0;
        for (int p = 0; p < 64; p++) begin
            measure(n, hi, pol, ack);
            sum += n;
            if (pol) pol_ones++;
        end
        checkOutput("mean 64 periods CK", sum, 272);
        checkOutput("mean 64 periods pol ones", pol_ones, 32);

        for (int d = 0; d < 2; d++) begin
            doReset();
            applyStimulus(10, 0);
            waitRise(ok);
            highs      = 0;
            rises      = 0;
            first_rise = -1;
            last       = 1'b1;
            for (int i = 0; i < 20; i++) begin
                if (i == 1) EN = 1'b0;
                if (i == 3 && d == 1) EN = 1'b1;
                if (DIV_OUT && !last) begin
                    rises++;
                    if (first_rise < 0) first_rise = i;
                end
                if (DIV_OUT && rises == 0) highs++;
                last = DIV_OUT;
                @(negedge CK);
            end
            if (d == 0) begin
                checkOutput("drain high cycles", highs, 2);
                checkOutput("drain extra rises", rises, 0);
                checkOutput("drain final DIV_OUT", int'(DIV_OUT), 0);
            end else begin
                checkOutput("drain restart rise index", first_rise, 6);
            end
        end

        EN = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
